// File: rtl/e_md_unit_pkg.sv
// Shared constants for the execute-stage multiply/divide unit:
// op encodings, FSM state encoding and default latencies.
package e_md_unit_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/e_md_unit.sv
// Multi-cycle MULT/DIV unit holding HI/LO. Results are computed from latched
// operands and committed only on the final busy edge.
module e_md_unit
    import e_md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        opa_q, opa_d;
    logic [31:0]        opb_q, opb_d;
    md_op_e             op_q, op_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    logic               accept;
    logic               done;
    logic [63:0]        prod_s, prod_u;
    logic [31:0]        quo_s, rem_s, quo_u, rem_u;
    logic               res_we;
    logic [31:0]        res_hi, res_lo;

    assign accept = start && (state_q == ST_IDLE);
    assign done   = (state_q == ST_RUN) && (cnt_q == CNT_W'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            op_q    <= MD_NONE;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept && is_multicycle(md_op)) state_d = ST_RUN;
            ST_RUN:  if (done) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        prod_s = $signed({{32{opa_q[31]}}, opa_q}) * $signed({{32{opb_q[31]}}, opb_q});
        prod_u = {32'b0, opa_q} * {32'b0, opb_q};
        quo_s  = $signed(opa_q) / $signed(opb_q);
        rem_s  = $signed(opa_q) % $signed(opb_q);
        quo_u  = opa_q / opb_q;
        rem_u  = opa_q % opb_q;
    end

    // Divide by zero suppresses the write; the signed overflow case is pinned
    // explicitly rather than trusting the tool's handling of it.
    always_comb begin
        res_we = 1'b0;
        res_hi = hi_q;
        res_lo = lo_q;
        case (op_q)
            MD_MULT: begin
                res_we = 1'b1;
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            MD_MULTU: begin
                res_we = 1'b1;
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            MD_DIV: begin
                if (opb_q != 32'd0) begin
                    res_we = 1'b1;
                    if (opa_q == 32'h8000_0000 && opb_q == 32'hFFFF_FFFF) begin
                        res_hi = 32'd0;
                        res_lo = 32'h8000_0000;
                    end else begin
                        res_hi = rem_s;
                        res_lo = quo_s;
                    end
                end
            end
            MD_DIVU: begin
                if (opb_q != 32'd0) begin
                    res_we = 1'b1;
                    res_hi = rem_u;
                    res_lo = quo_u;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        opa_d = opa_q;
        opb_d = opb_q;
        op_d  = op_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        if (state_q == ST_RUN) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (done && res_we) begin
                hi_d = res_hi;
                lo_d = res_lo;
            end
        end else if (accept) begin
            case (md_op)
                MD_MULT, MD_MULTU: begin
                    opa_d = a;
                    opb_d = b;
                    op_d  = md_op_e'(md_op);
                    cnt_d = CNT_W'(MULT_CYCLES);
                end
                MD_DIV, MD_DIVU: begin
                    opa_d = a;
                    opb_d = b;
                    op_d  = md_op_e'(md_op);
                    cnt_d = CNT_W'(DIV_CYCLES);
                end
                MD_MTHI: hi_d = a;
                MD_MTLO: lo_d = a;
                default: ;
            endcase
        end
    end

    always_comb begin
        busy   = (state_q == ST_RUN);
        hi     = hi_q;
        lo     = lo_q;
        md_out = 32'd0;
        if (md_op == MD_MFHI)      md_out = hi_q;
        else if (md_op == MD_MFLO) md_out = lo_q;
    end

endmodule

// File: doc/e_md_unit.md
# e_md_unit

Execute-stage multiply/divide unit of the five-stage pipeline. It accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO operation per start pulse and runs multi-cycle operations against an internal cycle counter. It holds the architectural HI/LO registers and drives the MFHI/MFLO read value that the EX/MEM register captures as its `md_in` field. The hazard unit uses `busy`, together with `start`, to stall any multiply/divide-class instruction waiting in D.

## Interface
Parameters:
- `MULT_CYCLES`, 5, busy cycles for MULT/MULTU (≥1)
- `DIV_CYCLES`, 10, busy cycles for DIV/DIVU (≥1)

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse; `md_op` valid for execution this cycle
- `md_op`  in  4  operation code (encodings in shared constants)
- `a`  in  32  rs operand (forwarded value)
- `b`  in  32  rt operand (forwarded value)
- `busy`  out  1  registered; high while a MULT/DIV is in flight
- `hi`  out  32  current HI register
- `lo`  out  32  current LO register
- `md_out`  out  32  combinational: `hi` if `md_op`==MFHI, `lo` if MFLO, else 0

## Operation
- Ops: MD_NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
- Internal state: IDLE and RUN (1-bit state), a down-counter, latched operands, latched op, HI, LO.
- IDLE, `start` with MULT/MULTU/DIV/DIVU:
  - latch `a`, `b` and the op
  - load the counter with MULT_CYCLES or DIV_CYCLES
  - go to RUN
- IDLE, `start` with MTHI/MTLO: write `a` to HI/LO at this edge. State stays IDLE and `busy` stays 0.
- IDLE, `start` with MFHI/MFLO/MD_NONE: no state change.
- RUN: decrement the counter each cycle. At the edge where the counter reaches 1:
  - write the result to HI/LO
  - return to IDLE
- Arithmetic, on the latched operands:
  - MULT: signed 32×32→64; HI = [63:32], LO = [31:0].
  - MULTU: the same, unsigned.
  - DIV: signed; LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - DIVU: unsigned.
  - Divisor 0: HI and LO are left unchanged. The busy duration is still DIV_CYCLES.
  - DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- `start` while `busy`: ignored entirely, including MTHI/MTLO. The hazard unit guarantees this never happens; a bench assertion flags it.
- `md_out` and `hi`/`lo` always show committed values. An in-flight result is never visible before commit.
- Reset (async, `reset`=0), applied at any time including mid-operation:
  - HI, LO, latched operands and counter → 0
  - state → IDLE, `busy` → 0
  - the in-flight result is discarded

## Timing
- `start` sampled high at edge E0 (MULT): `busy` = 1 from E0 through E0+MULT_CYCLES.
  - HI/LO are updated at edge E0+MULT_CYCLES.
  - `busy` falls at the same edge.
- A new `start` is accepted in the first cycle with `busy`=0. Back-to-back operations therefore have no dead cycle.
- MTHI/MTLO: HI/LO are visible on `hi`/`lo`/`md_out` in the cycle after the write edge.
- MFHI/MFLO: zero-latency combinational read of the registered HI/LO.
- Stall contract: the hazard unit stalls D while (`start` | `busy`) and a multiply/divide-class op sits in D.

## Structure
- Shared constants header holds the MD_* op encodings (4-bit) and the default cycle counts.
- Single module; no sub-module is required.
- The datapath uses behavioural `*`, `/` and `%` on the latched operands. `$signed` is applied for the signed ops.

## Test plan
- MULT: a=0xFFFFFFFE (−2), b=3 → `busy` high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands → HI=0x2, LO=0xFFFFFFFA.
- DIV: a=−7, b=2 → after 10 busy cycles LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). DIVU: a=7, b=2 → LO=3, HI=1.
- Divide by zero with preloaded HI=0x11, LO=0x22: DIV a=5, b=0 → busy for 10 cycles, HI/LO unchanged.
- MTHI a=0xDEADBEEF, then MFHI the next cycle → `md_out`=0xDEADBEEF. MTLO issued while `busy` → LO unchanged and assertion fires.
- Reset pulled low in busy cycle 3 of a MULT → `busy`=0 and HI=LO=0 immediately. After release, a fresh MULT 6×7 → LO=42 after 5 cycles.
- Back-to-back: MULT accepted in the cycle `busy` drops after a DIV → no idle gap, and both results commit in order.
